// File: rtl/pio_access_arbiter.sv
// Round-robin arbiter that serialises NREQ Avalon-MM requesters onto one
// zero-wait-state PIO slave port, one single-cycle access every three cycles.
module pio_access_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 2,
    localparam int unsigned GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_read,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_address,
    input  logic [NREQ*DW-1:0] req_writedata,
    output logic [NREQ-1:0]    req_waitrequest,
    output logic [DW-1:0]      req_readdata,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic               pio_chipselect,
    output logic               pio_write_n,
    output logic [AW-1:0]      pio_address,
    output logic [DW-1:0]      pio_writedata,
    input  logic [DW-1:0]      pio_readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     last_grant, last_grant_nxt, grant_nxt;
    logic [NREQ-1:0]   wait_nxt;
    logic [DW-1:0]     rdata_nxt, wdata_nxt;
    logic              busy_nxt, cs_nxt, write_n_nxt;
    logic [AW-1:0]     addr_nxt;

    logic [NREQ-1:0]   pending;
    logic              found;
    logic [GW-1:0]     winner;
    logic              win_write;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_data;
    int unsigned       scan_idx;

    // Pick the first pending requester after last_grant, then mux its payload.
    always_comb begin : arbitrate
        pending   = req_read | req_write;
        found     = 1'b0;
        winner    = '0;
        scan_idx  = 0;
        win_write = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = (32'(last_grant) + k) % NREQ;
            if (!found && pending[GW'(scan_idx)]) begin
                found  = 1'b1;
                winner = GW'(scan_idx);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (winner == GW'(k)) begin
                win_write = req_write[k];
                win_addr  = req_address[k*AW +: AW];
                win_data  = req_writedata[k*DW +: DW];
            end
        end
    end

    // Next state and next registered outputs; pio_* are only active in ACCESS.
    always_comb begin : fsm_next
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        wait_nxt       = '1;
        rdata_nxt      = req_readdata;
        busy_nxt       = 1'b0;
        cs_nxt         = 1'b0;
        write_n_nxt    = 1'b1;
        addr_nxt       = '0;
        wdata_nxt      = pio_writedata;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt   = ACCESS;
                    grant_nxt   = winner;
                    busy_nxt    = 1'b1;
                    cs_nxt      = 1'b1;
                    write_n_nxt = !win_write;
                    addr_nxt    = win_addr;
                    if (win_write) begin
                        wdata_nxt = win_data;
                    end
                end
            end
            ACCESS: begin
                state_nxt          = RESP;
                busy_nxt           = 1'b1;
                wait_nxt[grant_id] = 1'b0;
                // Read data is combinational from the slave during ACCESS.
                if (pio_write_n) begin
                    rdata_nxt = pio_readdata;
                end
            end
            RESP: begin
                state_nxt      = IDLE;
                last_grant_nxt = grant_id;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin : regs
        if (!reset_n) begin
            state           <= IDLE;
            last_grant      <= GW'(NREQ - 1);
            grant_id        <= '0;
            req_waitrequest <= '1;
            req_readdata    <= '0;
            busy            <= 1'b0;
            pio_chipselect  <= 1'b0;
            pio_write_n     <= 1'b1;
            pio_address     <= '0;
            pio_writedata   <= '0;
        end else begin
            state           <= state_nxt;
            last_grant      <= last_grant_nxt;
            grant_id        <= grant_nxt;
            req_waitrequest <= wait_nxt;
            req_readdata    <= rdata_nxt;
            busy            <= busy_nxt;
            pio_chipselect  <= cs_nxt;
            pio_write_n     <= write_n_nxt;
            pio_address     <= addr_nxt;
            pio_writedata   <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Bench for pio_access_arbiter: directed and random requester traffic checked
// against a transaction-level round-robin model and a PIO register-file slave.
module tb_pio_access_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 2;
    localparam int unsigned GW   = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_read;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_address;
    logic [NREQ*DW-1:0] req_writedata;
    logic [NREQ-1:0]    req_waitrequest;
    logic [DW-1:0]      req_readdata;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic               pio_chipselect;
    logic               pio_write_n;
    logic [AW-1:0]      pio_address;
    logic [DW-1:0]      pio_writedata;
    logic [DW-1:0]      pio_readdata;

    always #5 clk = ~clk;

    pio_access_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_writedata   (req_writedata),
        .req_waitrequest (req_waitrequest),
        .req_readdata    (req_readdata),
        .grant_id        (grant_id),
        .busy            (busy),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_address     (pio_address),
        .pio_writedata   (pio_writedata),
        .pio_readdata    (pio_readdata)
    );

    // PIO slave: four registers, combinational read, write on the clock edge.
    logic [DW-1:0] mem [4];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else if (pio_chipselect && !pio_write_n) begin
            mem[pio_address] <= pio_writedata;
        end
    end
    assign pio_readdata = mem[pio_address];

    int passed = 0;
    int total  = 0;

    // Reference model: requester intents plus the slave contents they imply.
    int          last_m;
    logic [31:0] mm [4];
    logic [31:0] rd_m;
    bit          act [NREQ];
    int          kind [NREQ];   // 0 read, 1 write, 2 read+write
    logic [1:0]  ad [NREQ];
    logic [31:0] dt [NREQ];
    int          remaining [NREQ];
    int          obs_cnt [NREQ];
    int          last_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_read[i]               = act[i] && (kind[i] != 1);
            req_write[i]              = act[i] && (kind[i] != 0);
            req_address[i*AW +: AW]   = ad[i];
            req_writedata[i*DW +: DW] = dt[i];
        end
    endtask

    task automatic clear_model();
        last_m = NREQ - 1;
        rd_m   = '0;
        for (int a = 0; a < 4; a++) mm[a] = '0;
        for (int i = 0; i < NREQ; i++) begin
            act[i] = 1'b0; kind[i] = 0; ad[i] = '0; dt[i] = '0; remaining[i] = 0;
        end
    endtask

    task automatic set_req(input int i, input int k, input logic [1:0] a, input logic [31:0] d, input int n);
        act[i] = 1'b1; kind[i] = k; ad[i] = a; dt[i] = d; remaining[i] = n;
    endtask

    task automatic rand_req(input int i);
        act[i]  = 1'b1;
        kind[i] = int'($urandom_range(0, 2));
        ad[i]   = 2'($urandom_range(0, 3));
        dt[i]   = $urandom;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_model();
        apply_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs the current requests to completion, checking every cycle at negedge.
    task automatic run(input int budget);
        int cyc, w, due_acc, due_resp;
        bit infl, just, exp_acc, exp_resp, ewr, any, got;
        logic [1:0] ea;
        logic [31:0] ed, erd;
        logic [NREQ-1:0] exp_wait;
        cyc = 0; infl = 0; w = 0; due_acc = -1; due_resp = -1;
        ewr = 0; ea = '0; ed = '0; erd = '0;
        for (int i = 0; i < NREQ; i++) obs_cnt[i] = 0;
        apply_inputs();
        forever begin
            just     = 0;
            exp_acc  = infl && (cyc == due_acc);
            exp_resp = infl && (cyc == due_resp);
            if (exp_resp && !ewr) rd_m = erd;
            check("chipselect", 32'(pio_chipselect), 32'(exp_acc));
            if (exp_acc) begin
                check("write_n", 32'(pio_write_n), 32'(!ewr));
                check("address", 32'(pio_address), 32'(ea));
                if (ewr) check("writedata", pio_writedata, ed);
            end else begin
                check("write_n_idle", 32'(pio_write_n), 32'(1));
            end
            exp_wait = '1;
            if (exp_resp) exp_wait[w] = 1'b0;
            check("waitrequest", 32'(req_waitrequest), 32'(exp_wait));
            check("busy", 32'(busy), 32'(exp_acc || exp_resp));
            check("readdata", req_readdata, rd_m);
            if (exp_resp) check("grant_id", 32'(grant_id), 32'(w));
            for (int i = 0; i < NREQ; i++) if (!req_waitrequest[i]) obs_cnt[i]++;
            if (exp_resp) begin
                last_resp = cyc;
                act[w] = 1'b0;
                remaining[w]--;
                if (remaining[w] > 0) rand_req(w);
                apply_inputs();
                infl = 0;
                just = 1;
            end
            any = 0;
            for (int i = 0; i < NREQ; i++) any |= act[i];
            if (!infl && !just && any) begin
                got = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!got && act[(last_m + k) % NREQ]) begin
                        got = 1;
                        w = (last_m + k) % NREQ;
                    end
                end
                ewr = (kind[w] != 0);
                ea  = ad[w];
                ed  = dt[w];
                if (ewr) mm[ea] = ed;
                else erd = mm[ea];
                last_m   = w;
                due_acc  = cyc + 1;
                due_resp = cyc + 2;
                infl     = 1;
            end
            if (!infl && !just && !any) break;
            if (cyc >= budget) begin
                total++;
                $error("FAIL run_budget observed=%0d cycles expected completion", cyc);
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        reset_n = 1'b1;
        clear_model();
        apply_inputs();
        #1;
        do_reset();

        check("rst_chipselect", 32'(pio_chipselect), 32'(0));
        check("rst_write_n", 32'(pio_write_n), 32'(1));
        check("rst_address", 32'(pio_address), 32'(0));
        check("rst_writedata", pio_writedata, 32'(0));
        check("rst_waitrequest", 32'(req_waitrequest), 32'hF);
        check("rst_readdata", req_readdata, 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));

        // Single write: three cycles end to end.
        set_req(0, 1, 2'd0, 32'hDEADBEEF, 1);
        run(20);
        check("single_write_latency", 32'(last_resp), 32'(2));
        check("single_write_slave", mem[0], 32'hDEADBEEF);

        // Single read by r1 of a known slave value.
        set_req(0, 1, 2'd0, 32'h12345678, 1);
        run(20);
        set_req(1, 0, 2'd0, 32'h0, 1);
        run(20);
        check("single_read_data", req_readdata, 32'h12345678);

        // Read and write together: performed as a write, readdata untouched.
        set_req(0, 2, 2'd1, 32'h5, 1);
        run(20);
        check("rw_both_slave", mem[1], 32'h5);
        check("rw_both_readdata", req_readdata, 32'h12345678);

        // Contention straight after reset: r0 first, r1 second, six cycles.
        do_reset();
        set_req(0, 1, 2'd2, 32'hAA, 1);
        set_req(1, 0, 2'd2, 32'h0, 1);
        run(30);
        check("contention_latency", 32'(last_resp), 32'(5));
        check("contention_read", req_readdata, 32'hAA);

        // Sustained fairness: all four requesters, ten accesses each.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rand_req(i);
            remaining[i] = 10;
        end
        run(400);
        for (int i = 0; i < NREQ; i++) check($sformatf("fair_count_r%0d", i), 32'(obs_cnt[i]), 32'(10));

        // Random mixes of requesters and access kinds.
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rand_req(i);
                    remaining[i] = int'($urandom_range(1, 3));
                end
            end
            run(200);
        end
        for (int a = 0; a < 4; a++) check($sformatf("slave_reg%0d", a), mem[a], mm[a]);

        // Reset during ACCESS abandons the transfer without a response.
        set_req(2, 1, 2'd1, 32'hCAFE0000, 1);
        apply_inputs();
        @(negedge clk);
        check("mid_access_cs", 32'(pio_chipselect), 32'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_cs", 32'(pio_chipselect), 32'(0));
        check("mid_rst_wait", 32'(req_waitrequest), 32'hF);
        check("mid_rst_busy", 32'(busy), 32'(0));
        clear_model();
        apply_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("in_rst_wait", 32'(req_waitrequest), 32'hF);
            check("in_rst_cs", 32'(pio_chipselect), 32'(0));
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("abandoned_write", mem[1], 32'(0));
        set_req(2, 1, 2'd3, 32'h0BAD0002, 1);
        set_req(0, 1, 2'd3, 32'h600D0000, 1);
        run(30);
        check("post_rst_last_writer", mem[3], 32'h0BAD0002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pio_access_arbiter.md
# pio_access_arbiter

Round-robin arbiter that shares one Avalon-MM PIO slave port (2-bit address, 32-bit data, zero-wait-state, combinational readdata) between NREQ Avalon-MM master requesters, e.g. the HPS lightweight bridge and the local LBM control FSM. It serialises their reads and writes into single-cycle slave accesses. It holds each requester in waitrequest until that requester's access completes. It sits between the requesters and the PIO slave (direction, control or status registers) in the Computer_System fabric.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- DW, 32, data width
- AW, 2, slave address width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_read  in  NREQ  per-requester read request
- req_write  in  NREQ  per-requester write request
- req_address  in  NREQ*AW  flattened; requester i at [i*AW +: AW]
- req_writedata  in  NREQ*DW  flattened; requester i at [i*DW +: DW]
- req_waitrequest  out  NREQ  per-requester stall; low for exactly one cycle when that requester's access completes
- req_readdata  out  DW  shared read return; valid in the cycle the reading requester's waitrequest is low
- grant_id  out  clog2(NREQ) (min 1)  index of the requester currently owning the slave
- busy  out  1  high in ACCESS and RESP
- pio_chipselect  out  1  slave chipselect
- pio_write_n  out  1  slave write strobe, active-low
- pio_address  out  AW  slave address
- pio_writedata  out  DW  slave write data
- pio_readdata  in  DW  slave read data, combinational from address

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requester i is pending when req_read[i] or req_write[i] is high.
  - If any requester is pending, the winner is the first pending index scanning upward from last_grant+1, wrapping modulo NREQ.
  - On the winner: register grant_id, the winner's address and writedata, and the access kind (write when req_write is high, else read). Go to ACCESS.
  - If nothing is pending, stay in IDLE.
- ACCESS (one cycle):
  - pio_chipselect=1 and pio_address=latched address.
  - Write: pio_write_n=0 and pio_writedata=latched data.
  - Read: pio_write_n=1, and pio_readdata is captured into the req_readdata register at the end of the cycle.
  - Go to RESP.
- RESP (one cycle):
  - req_waitrequest[grant_id]=0, and last_grant is set to grant_id.
  - Go to IDLE.
- req_read and req_write both high: treated as a write; no read data is captured.
- A requester that drops its request after being latched still gets its access performed and its RESP pulse issued. Requests are sampled only in IDLE.
- req_readdata holds its last captured value until the next read's ACCESS cycle.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, last_grant=NREQ-1, so requester 0 wins first.
  - req_waitrequest all ones.
  - req_readdata=0, grant_id=0, busy=0.
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
- All outputs are registered. The pio_* signals are asserted only in ACCESS, and pio_writedata is held at its last value outside ACCESS.
- Latency: a request visible at clock edge k in IDLE gives ACCESS in cycle k+1 and RESP (waitrequest low) in cycle k+2. The transaction is accepted at the edge ending k+2.
- Throughput: one access per 3 cycles. The next arbitration is decided in the IDLE cycle that follows RESP.
- Non-granted requesters see waitrequest=1 throughout.
- Reset mid-ACCESS or mid-RESP: the access is abandoned with no RESP pulse. The requester must reissue after reset.

## Test plan
- Single write:
  - Stimulus: r0 writes 0xDEADBEEF to address 0.
  - Response: pio_chipselect=1 and pio_write_n=0 with 0xDEADBEEF for exactly one cycle, 1 cycle after the request edge. req_waitrequest[0]=0 one cycle later. Total 3 cycles.
- Single read:
  - Stimulus: slave model returns 0x1234_5678 at address 0; r1 reads address 0.
  - Response: req_readdata=0x12345678 in the cycle req_waitrequest[1]=0, with pio_write_n held at 1.
- Contention after reset:
  - Stimulus: r0 and r1 request in the same cycle.
  - Response: r0 is served first (grant_id=0), then r1 on the next arbitration with no idle gap beyond IDLE. 6 cycles total.
- Sustained fairness:
  - Stimulus: NREQ=4, all requesters continuously requesting for 40 accesses.
  - Response: grant order 0,1,2,3,0,... with exactly 10 grants each.
- Read and write together:
  - Stimulus: r0 asserts req_read=req_write=1 with data 0x5.
  - Response: a slave write of 0x5, and req_readdata unchanged from its prior value.
- Reset mid-access:
  - Stimulus: assert reset_n=0 during ACCESS.
  - Response: pio_chipselect drops immediately, all waitrequests go to 1, no RESP pulse is issued, and the next arbitration after release grants r0.
